// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: steps FETCH/DECODE/EXEC/WB, drives the PC command
// and phase enables, with a phase-stretch divider and run/step/halt controls.
module cpu_sequencer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  output logic [1:0]       en_pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // A divider of 0 behaves like 1: every phase then ends on its first cycle.
  localparam logic [31:0] DIV_LAST = (TICK_DIV == 0) ? 32'd0 : TICK_DIV - 32'd1;

  state_t      state, state_nxt;
  logic [31:0] div_cnt;
  logic        step_d, step_pend, pend_nxt;
  logic        step_edge, phase_end, in_instr;

  logic [1:0]  en_pc_nxt;
  logic        fetch_nxt, decode_nxt, exec_nxt, wb_nxt, busy_nxt, halted_nxt;

  assign step_edge = step & ~step_d;
  assign phase_end = (div_cnt == DIV_LAST);
  assign in_instr  = (state == FETCH) || (state == DECODE) ||
                     (state == EXEC)  || (state == WB);
  assign phase     = state;

  always_comb begin
    state_nxt = state;
    pend_nxt  = step_pend;
    if (in_instr && step_edge) pend_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (run || step_edge || step_pend) begin
          state_nxt = FETCH;
          pend_nxt  = 1'b0;
        end
      end
      FETCH:  if (phase_end) state_nxt = DECODE;
      DECODE: if (phase_end) state_nxt = EXEC;
      EXEC:   if (phase_end) state_nxt = WB;
      WB: begin
        if (phase_end) begin
          if (halt_req) begin
            state_nxt = HALT;
          end else if (run) begin
            state_nxt = FETCH;
          end else if (step_pend) begin
            state_nxt = FETCH;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land with the state register.
  always_comb begin
    en_pc_nxt  = 2'b00;
    fetch_nxt  = 1'b0;
    decode_nxt = 1'b0;
    exec_nxt   = 1'b0;
    wb_nxt     = 1'b0;
    busy_nxt   = 1'b0;
    halted_nxt = 1'b0;
    case (state_nxt)
      FETCH:  begin en_pc_nxt = 2'b10; fetch_nxt  = 1'b1; busy_nxt = 1'b1; end
      DECODE: begin en_pc_nxt = 2'b01; decode_nxt = 1'b1; busy_nxt = 1'b1; end
      EXEC:   begin en_pc_nxt = 2'b01; exec_nxt   = 1'b1; busy_nxt = 1'b1; end
      WB:     begin en_pc_nxt = 2'b11; wb_nxt     = 1'b1; busy_nxt = 1'b1; end
      HALT:   halted_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      div_cnt     <= '0;
      step_d      <= 1'b0;
      step_pend   <= 1'b0;
      instr_count <= '0;
      en_pc       <= 2'b00;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_d    <= step;
      step_pend <= pend_nxt;
      div_cnt   <= (in_instr && !phase_end) ? div_cnt + 32'd1 : 32'd0;
      if (state == WB && phase_end) instr_count <= instr_count + 1'b1;
      en_pc     <= en_pc_nxt;
      fetch_en  <= fetch_nxt;
      decode_en <= decode_nxt;
      exec_en   <= exec_nxt;
      wb_en     <= wb_nxt;
      busy      <= busy_nxt;
      halted    <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed per-cycle vectors on a TICK_DIV=4
// instance and a TICK_DIV=1, CNT_W=4 instance.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_run = 0, a_step = 0, a_halt = 0, a_clear = 1;
  logic b_run = 0, b_step = 0, b_halt = 0, b_clear = 1;

  logic [1:0]  a_en_pc, b_en_pc;
  logic        a_fetch, a_dec, a_exec, a_wb, a_busy, a_halted;
  logic        b_fetch, b_dec, b_exec, b_wb, b_busy, b_halted;
  logic [2:0]  a_phase, b_phase;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  cpu_sequencer #(.TICK_DIV(4), .CNT_W(16)) dut_a (
    .clk(clk), .clear(a_clear), .run(a_run), .step(a_step), .halt_req(a_halt),
    .en_pc(a_en_pc), .fetch_en(a_fetch), .decode_en(a_dec), .exec_en(a_exec),
    .wb_en(a_wb), .busy(a_busy), .halted(a_halted), .phase(a_phase),
    .instr_count(a_cnt)
  );

  cpu_sequencer #(.TICK_DIV(1), .CNT_W(4)) dut_b (
    .clk(clk), .clear(b_clear), .run(b_run), .step(b_step), .halt_req(b_halt),
    .en_pc(b_en_pc), .fetch_en(b_fetch), .decode_en(b_dec), .exec_en(b_exec),
    .wb_en(b_wb), .busy(b_busy), .halted(b_halted), .phase(b_phase),
    .instr_count(b_cnt)
  );

  typedef struct {
    bit              sel;
    logic [2:0]      phase;
    logic [15:0]     cnt;
    logic [8*16-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  function automatic logic [1:0] expEnPc(input logic [2:0] ph);
    case (ph)
      3'd1:       return 2'b10;
      3'd2, 3'd3: return 2'b01;
      3'd4:       return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [26:0] act, want;
    if (e.sel == A)
      act = {a_phase, a_en_pc, a_fetch, a_dec, a_exec, a_wb, a_busy, a_halted, a_cnt};
    else
      act = {b_phase, b_en_pc, b_fetch, b_dec, b_exec, b_wb, b_busy, b_halted, 12'd0, b_cnt};
    want = {e.phase, expEnPc(e.phase), e.phase == 3'd1, e.phase == 3'd2,
            e.phase == 3'd3, e.phase == 3'd4, (e.phase >= 3'd1 && e.phase <= 3'd4),
            e.phase == 3'd5, e.cnt};
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %0s dut=%0d got={ph,pc,en,bsy,hlt,cnt}=%h want=%h",
               e.tag, e.sel, act, want);
    end
  endtask

  // Monitor: one expectation per edge that the stimulus scheduled.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  // Drive inputs ahead of the next edge and queue the state expected after it.
  task automatic applyStimulus(input bit sel, input logic r, input logic s,
                               input logic h, input logic c, input logic [2:0] ph,
                               input logic [15:0] cnt, input logic [8*16-1:0] tag);
    exp_t e;
    @(negedge clk);
    if (sel == A) begin a_run = r; a_step = s; a_halt = h; a_clear = c; end
    else          begin b_run = r; b_step = s; b_halt = h; b_clear = c; end
    e.sel = sel; e.phase = ph; e.cnt = cnt; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic applyCycles(input bit sel, input logic r, input logic s,
                             input logic h, input logic c, input logic [2:0] ph,
                             input logic [15:0] cnt, input int n,
                             input logic [8*16-1:0] tag);
    for (int i = 0; i < n; i++) applyStimulus(sel, r, s, h, c, ph, cnt, tag);
  endtask

  initial begin
    applyStimulus(A, 0, 0, 0, 1, 3'd0, 16'd0, "reset_a");
    applyStimulus(B, 0, 0, 0, 1, 3'd0, 16'd0, "reset_b");

    // Reset mid-phase after one retired instruction.
    applyCycles(A, 1, 0, 0, 0, 3'd1, 16'd0, 4, "t1_fetch");
    applyCycles(A, 1, 0, 0, 0, 3'd2, 16'd0, 4, "t1_decode");
    applyCycles(A, 1, 0, 0, 0, 3'd3, 16'd0, 4, "t1_exec");
    applyCycles(A, 1, 0, 0, 0, 3'd4, 16'd0, 4, "t1_wb");
    applyCycles(A, 1, 0, 0, 0, 3'd1, 16'd1, 4, "t1_fetch2");
    applyCycles(A, 1, 0, 0, 0, 3'd2, 16'd1, 4, "t1_decode2");
    applyCycles(A, 1, 0, 0, 0, 3'd3, 16'd1, 2, "t1_exec2");
    applyStimulus(A, 1, 0, 0, 1, 3'd0, 16'd0, "t1_clear");
    applyStimulus(A, 1, 0, 0, 0, 3'd1, 16'd0, "t1_refetch");
    applyStimulus(A, 0, 0, 0, 1, 3'd0, 16'd0, "t1_clear2");

    // Single step, then a pending step and a dropped third edge.
    applyCycles(A, 0, 1, 0, 0, 3'd1, 16'd0, 4, "t3_fetch");
    applyCycles(A, 0, 0, 0, 0, 3'd2, 16'd0, 4, "t3_decode");
    applyCycles(A, 0, 0, 0, 0, 3'd3, 16'd0, 4, "t3_exec");
    applyCycles(A, 0, 0, 0, 0, 3'd4, 16'd0, 4, "t3_wb");
    applyCycles(A, 0, 0, 0, 0, 3'd0, 16'd1, 3, "t3_idle");
    applyStimulus(A, 0, 1, 0, 0, 3'd1, 16'd1, "t3_step2");
    applyCycles(A, 0, 0, 0, 0, 3'd1, 16'd1, 3, "t3_fetch2");
    applyStimulus(A, 0, 1, 0, 0, 3'd2, 16'd1, "t3_edge_pend");
    applyStimulus(A, 0, 0, 0, 0, 3'd2, 16'd1, "t3_decode2");
    applyStimulus(A, 0, 1, 0, 0, 3'd2, 16'd1, "t3_edge_drop");
    applyStimulus(A, 0, 0, 0, 0, 3'd2, 16'd1, "t3_decode2");
    applyCycles(A, 0, 0, 0, 0, 3'd3, 16'd1, 4, "t3_exec2");
    applyCycles(A, 0, 0, 0, 0, 3'd4, 16'd1, 4, "t3_wb2");
    applyCycles(A, 0, 0, 0, 0, 3'd1, 16'd2, 4, "t3_pend_fetch");
    applyCycles(A, 0, 0, 0, 0, 3'd2, 16'd2, 4, "t3_pend_decode");
    applyCycles(A, 0, 0, 0, 0, 3'd3, 16'd2, 4, "t3_pend_exec");
    applyCycles(A, 0, 0, 0, 0, 3'd4, 16'd2, 4, "t3_pend_wb");
    applyCycles(A, 0, 0, 0, 0, 3'd0, 16'd3, 3, "t3_idle_end");

    // Halt requested during DECODE finishes the instruction first.
    applyStimulus(A, 0, 0, 0, 1, 3'd0, 16'd0, "t4_clear");
    applyCycles(A, 1, 0, 0, 0, 3'd1, 16'd0, 4, "t4_fetch");
    applyCycles(A, 1, 0, 1, 0, 3'd2, 16'd0, 4, "t4_decode");
    applyCycles(A, 1, 0, 1, 0, 3'd3, 16'd0, 4, "t4_exec");
    applyCycles(A, 1, 0, 1, 0, 3'd4, 16'd0, 4, "t4_wb");
    applyCycles(A, 1, 0, 1, 0, 3'd5, 16'd1, 2, "t4_halt");
    applyStimulus(A, 1, 1, 0, 0, 3'd5, 16'd1, "t4_halt_tog1");
    applyStimulus(A, 0, 0, 0, 0, 3'd5, 16'd1, "t4_halt_tog2");
    applyStimulus(A, 0, 1, 0, 0, 3'd5, 16'd1, "t4_halt_tog3");
    applyStimulus(A, 1, 0, 1, 0, 3'd5, 16'd1, "t4_halt_tog4");
    applyStimulus(A, 0, 0, 0, 1, 3'd0, 16'd0, "t4_clear_halt");
    applyStimulus(A, 0, 0, 0, 0, 3'd0, 16'd0, "t4_idle");

    // IDLE priority: run beats a step edge; halt_req beats run.
    applyStimulus(A, 1, 1, 0, 0, 3'd1, 16'd0, "t5_run_step");
    applyCycles(A, 0, 1, 0, 0, 3'd1, 16'd0, 3, "t5_fetch");
    applyCycles(A, 0, 0, 0, 0, 3'd2, 16'd0, 4, "t5_decode");
    applyCycles(A, 0, 0, 0, 0, 3'd3, 16'd0, 4, "t5_exec");
    applyCycles(A, 0, 0, 0, 0, 3'd4, 16'd0, 4, "t5_wb");
    applyCycles(A, 0, 0, 0, 0, 3'd0, 16'd1, 2, "t5_no_requeue");
    applyCycles(A, 1, 0, 1, 0, 3'd5, 16'd1, 2, "t5_halt_run");
    applyStimulus(A, 0, 0, 0, 1, 3'd0, 16'd0, "t5_clear");

    // Free run at TICK_DIV=1 through the 4-bit counter wrap.
    applyStimulus(B, 0, 0, 0, 0, 3'd0, 16'd0, "t2_idle");
    for (int i = 0; i < 72; i++)
      applyStimulus(B, 1, 0, 0, 0, 3'(i % 4 + 1), 16'((i / 4) % 16), "t2_run");
    applyCycles(B, 0, 0, 0, 0, 3'd0, 16'd2, 2, "t2_stop");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
